// File: rtl/mem_stage.sv
// mem_stage: data memory access stage with wait states, stall generation and MEM/WB register.
// Optional feature macro: MEM_STAGE_MISALIGN_EN (suppress and flag misaligned accesses).
module mem_stage #(
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        regWrite_in,
   input  logic        memRead_in,
   input  logic        memWrite_in,
   input  logic [1:0]  memtoReg_in,
   input  logic [31:0] PC_in,
   input  logic [31:0] ALUOut_in,
   input  logic [31:0] readData2_in,
   input  logic [4:0]  rd_in,
   output logic        stall_out,
   output logic        regWrite_out,
   output logic [1:0]  memtoReg_out,
   output logic [4:0]  rd_out,
   output logic [31:0] PC_out,
   output logic [31:0] ALUOut_out,
   output logic [31:0] readData_out,
   output logic        misalign_out
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   logic          access, mis, is_rd, wr_en;
   logic          regWrite_q, regWrite_d, misalign_q, misalign_d;
   logic [1:0]    memtoReg_q, memtoReg_d;
   logic [4:0]    rd_q, rd_d;
   logic [31:0]   pc_q, pc_d, alu_q, alu_d, rdata_q, rdata_d;
   logic          unused_addr;
   assign idx         = ALUOut_in[AW+1:2];
   assign unused_addr = ^{ALUOut_in[31:AW+2], ALUOut_in[1:0]};
   assign access      = memRead_in | memWrite_in;
   assign is_rd       = memRead_in & ~memWrite_in;
`ifdef MEM_STAGE_MISALIGN_EN
   assign mis = access & (|ALUOut_in[1:0]);
`else
   assign mis = 1'b0;
`endif
   assign wr_en = ~stall_out & memWrite_in & ~mis;
   // Wait-state sequencing: stall while the access is in flight, complete when the count runs out.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_out = 1'b0;
      if (state_q == IDLE) begin
         if (access && WAIT_STATES > 0) begin
            stall_out = 1'b1;
            state_d   = BUSY;
            cnt_d     = CNT_INIT;
         end
      end else if (cnt_q != '0) begin
         stall_out = 1'b1;
         cnt_d     = cnt_q - 1'b1;
      end else begin
         state_d = IDLE;
      end
   end
   // MEM/WB next values: a bubble while stalling, otherwise the instruction and its load data.
   always_comb begin
      regWrite_d = 1'b0;
      memtoReg_d = '0;
      rd_d       = '0;
      pc_d       = '0;
      alu_d      = '0;
      rdata_d    = '0;
      misalign_d = 1'b0;
      if (!stall_out) begin
         regWrite_d = regWrite_in & ~(mis & is_rd);
         memtoReg_d = memtoReg_in;
         rd_d       = rd_in;
         pc_d       = PC_in;
         alu_d      = ALUOut_in;
         rdata_d    = (is_rd & ~mis) ? mem[idx] : '0;
         misalign_d = mis;
      end
   end
   // FSM state, wait counter and MEM/WB pipeline register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         regWrite_q <= 1'b0;
         memtoReg_q <= '0;
         rd_q       <= '0;
         pc_q       <= '0;
         alu_q      <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         regWrite_q <= regWrite_d;
         memtoReg_q <= memtoReg_d;
         rd_q       <= rd_d;
         pc_q       <= pc_d;
         alu_q      <= alu_d;
         rdata_q    <= rdata_d;
         misalign_q <= misalign_d;
      end
   end
   // Store commits only on the completion edge and never while reset is held.
   always_ff @(posedge clk) begin
      if (rst && wr_en) mem[idx] <= readData2_in;
   end
   assign regWrite_out = regWrite_q;
   assign memtoReg_out = memtoReg_q;
   assign rd_out       = rd_q;
   assign PC_out       = pc_q;
   assign ALUOut_out   = alu_q;
   assign readData_out = rdata_q;
   assign misalign_out = misalign_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage (WAIT_STATES=2 main DUT, WAIT_STATES=0 stall check).
module tb_mem_stage;
`ifdef MEM_STAGE_MISALIGN_EN
   localparam bit M = 1'b1;
`else
   localparam bit M = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b0;
   logic regWrite_in = 0, memRead_in = 0, memWrite_in = 0;
   logic [1:0] memtoReg_in = 0;
   logic [31:0] PC_in = 0, ALUOut_in = 0, readData2_in = 0;
   logic [4:0] rd_in = 0;
   logic stall_out, regWrite_out, misalign_out;
   logic [1:0] memtoReg_out;
   logic [4:0] rd_out;
   logic [31:0] PC_out, ALUOut_out, readData_out;
   logic s0, rw0, mis0;
   logic [1:0] mtr0;
   logic [4:0] rd0;
   logic [31:0] pc0, alu0, rdat0;

   mem_stage #(.DEPTH(256), .WAIT_STATES(2)) dut (
      .clk(clk), .rst(rst), .regWrite_in(regWrite_in), .memRead_in(memRead_in),
      .memWrite_in(memWrite_in), .memtoReg_in(memtoReg_in), .PC_in(PC_in),
      .ALUOut_in(ALUOut_in), .readData2_in(readData2_in), .rd_in(rd_in),
      .stall_out(stall_out), .regWrite_out(regWrite_out), .memtoReg_out(memtoReg_out),
      .rd_out(rd_out), .PC_out(PC_out), .ALUOut_out(ALUOut_out),
      .readData_out(readData_out), .misalign_out(misalign_out));

   mem_stage #(.DEPTH(256), .WAIT_STATES(0)) u0 (
      .clk(clk), .rst(rst), .regWrite_in(regWrite_in), .memRead_in(memRead_in),
      .memWrite_in(memWrite_in), .memtoReg_in(memtoReg_in), .PC_in(PC_in),
      .ALUOut_in(ALUOut_in), .readData2_in(readData2_in), .rd_in(rd_in),
      .stall_out(s0), .regWrite_out(rw0), .memtoReg_out(mtr0),
      .rd_out(rd0), .PC_out(pc0), .ALUOut_out(alu0),
      .readData_out(rdat0), .misalign_out(mis0));

   always #5 clk = ~clk;

   typedef struct {
      logic        rw;
      logic [1:0]  mtr;
      logic [4:0]  rd;
      logic [31:0] pc, alu, rdata;
      logic        mis;
   } exp_t;
   exp_t q[$];
   exp_t e;
   int checks = 0, errors = 0;
   logic active = 1'b0, take = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (take) begin
         if (q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
         else begin
            e = q.pop_front();
            chk("regWrite", {31'd0, regWrite_out}, {31'd0, e.rw});
            chk("memtoReg", {30'd0, memtoReg_out}, {30'd0, e.mtr});
            chk("rd", {27'd0, rd_out}, {27'd0, e.rd});
            chk("PC", PC_out, e.pc);
            chk("ALUOut", ALUOut_out, e.alu);
            chk("readData", readData_out, e.rdata);
            chk("misalign", {31'd0, misalign_out}, {31'd0, e.mis});
         end
      end
      take = active && !stall_out;
      if (active) chk("ws0_stall", {31'd0, s0}, 32'd0);
   end

   task automatic issue(input logic rw, input logic mr, input logic mw, input logic [1:0] mtr,
                        input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] d2,
                        input logic [4:0] rd, input logic e_rw, input logic [31:0] e_rdata,
                        input logic e_mis);
      exp_t x;
      int st = 0;
      @(posedge clk); #1;
      regWrite_in = rw; memRead_in = mr; memWrite_in = mw; memtoReg_in = mtr;
      PC_in = pc; ALUOut_in = alu; readData2_in = d2; rd_in = rd; active = 1'b1;
      x.rw = e_rw; x.mtr = mtr; x.rd = rd; x.pc = pc; x.alu = alu; x.rdata = e_rdata; x.mis = e_mis;
      q.push_back(x);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!stall_out) break;
         st++;
      end
      chk("stall_cycles", st, (mr | mw) ? 32'd2 : 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_regWrite", {31'd0, regWrite_out}, 32'd0);
      chk("rst_PC", PC_out, 32'd0);
      chk("rst_readData", readData_out, 32'd0);
      chk("rst_stall", {31'd0, stall_out}, 32'd0);
      rst = 1'b1;
      issue(0, 0, 1, 0, 32'h100, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 0);
      issue(1, 1, 0, 1, 32'h104, 32'h10, 32'h0, 5, 1, 32'hDEADBEEF, 0);
      issue(1, 0, 0, 0, 32'h108, 32'h1234, 32'h0, 7, 1, 32'h0, 0);
      issue(0, 0, 1, 0, 32'h10C, 32'h400, 32'h55, 0, 0, 32'h0, 0);
      issue(1, 1, 0, 1, 32'h110, 32'h0, 32'h0, 3, 1, 32'h55, 0);
      issue(1, 1, 1, 1, 32'h114, 32'h20, 32'hA5, 9, 1, 32'h0, 0);
      issue(1, 1, 0, 1, 32'h118, 32'h20, 32'h0, 10, 1, 32'hA5, 0);
      issue(0, 0, 1, 0, 32'h11C, 32'h22, 32'h77, 0, 0, 32'h0, M);
      issue(1, 1, 0, 1, 32'h120, 32'h20, 32'h0, 11, 1, M ? 32'hA5 : 32'h77, 0);
      issue(1, 1, 0, 1, 32'h124, 32'h11, 32'h0, 4, !M, M ? 32'h0 : 32'hDEADBEEF, M);
      issue(1, 0, 0, 2, 32'h128, 32'hABC, 32'h0, 12, 1, 32'h0, 0);
      issue(0, 0, 1, 0, 32'h12C, 32'h40, 32'h11111111, 0, 0, 32'h0, 0);
      @(posedge clk); #1;
      active = 1'b0;
      regWrite_in = 1; memRead_in = 0; memWrite_in = 1; memtoReg_in = 0;
      PC_in = 32'h130; ALUOut_in = 32'h40; readData2_in = 32'h22222222; rd_in = 6;
      @(posedge clk); #1;
      chk("pre_rst_stall", {31'd0, stall_out}, 32'd1);
      rst = 1'b0;
      memWrite_in = 1'b0;
      #1;
      chk("mid_rst_stall", {31'd0, stall_out}, 32'd0);
      chk("mid_rst_regWrite", {31'd0, regWrite_out}, 32'd0);
      chk("mid_rst_rd", {27'd0, rd_out}, 32'd0);
      chk("mid_rst_PC", PC_out, 32'd0);
      chk("mid_rst_ALUOut", ALUOut_out, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      issue(1, 1, 0, 1, 32'h134, 32'h40, 32'h0, 8, 1, 32'h11111111, 0);
      @(posedge clk); #1;
      regWrite_in = 0; memRead_in = 0; memWrite_in = 0; active = 1'b0;
      repeat (3) @(posedge clk);
      chk("sb_drained", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline, sitting directly downstream of the EX/MEM pipeline register and feeding the write-back mux. It holds the word-addressed data memory and performs loads and stores with a configurable number of wait states. It asserts a stall so upstream stages hold while an access is in progress. It also registers the MEM/WB boundary, so its outputs are the MEM/WB pipeline values.

## Interface
- DEPTH, 256: data memory size in 32-bit words; power of two.
- WAIT_STATES, 2: extra cycles per load/store; 0 gives a single-cycle access.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- regWrite_in, memRead_in, memWrite_in  input  1 each  control bits from EX/MEM.
- memtoReg_in  input  2  write-back select from EX/MEM.
- PC_in, ALUOut_in, readData2_in  input  32 each  PC, effective address/ALU result, store data.
- rd_in  input  5  destination register.
- stall_out  output  1  combinational; upstream must hold all *_in values stable while high.
- regWrite_out  output  1  MEM/WB register.
- memtoReg_out  output  2  MEM/WB register.
- rd_out  output  5  MEM/WB register.
- PC_out, ALUOut_out, readData_out  output  32 each  MEM/WB registers.
- misalign_out  output  1  registered misalignment flag; constant 0 unless the macro is defined.

## Operation
- An access is any cycle with memRead_in=1 or memWrite_in=1.
- Word index is ALUOut_in[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH words.
- If memRead_in and memWrite_in are both 1, the access is treated as a write and readData_out loads 0.
- Memory reads are combinational from the array. Writes commit on the completion edge only.
- The FSM has two states, IDLE and BUSY, with a down-counter cnt of width clog2(WAIT_STATES+1).
  - IDLE, no access: stall_out=0. Outputs load the *_in values on the edge. readData_out=0.
  - IDLE, access, WAIT_STATES=0: completes this edge. stall_out=0.
  - IDLE, access, WAIT_STATES>0: stall_out=1. Next state is BUSY with cnt<=WAIT_STATES-1. Outputs load a bubble.
  - BUSY, cnt!=0: stall_out=1. cnt decrements. Outputs load a bubble.
  - BUSY, cnt==0: stall_out=0. The access completes on this edge and the next state is IDLE.
- A bubble is regWrite_out=0, memtoReg_out=0, rd_out=0, PC_out/ALUOut_out/readData_out=0, misalign_out=0.
- On completion, outputs load the *_in values. readData_out loads mem[index] for a read and 0 for a write. A store writes readData2_in to mem[index].
- Reset clears state to IDLE, cnt to 0, and all outputs to 0. Memory contents are not reset.
- Reset asserted mid-access abandons the access. A pending store is not written.

## Timing
- Latency is WAIT_STATES+1 cycles per access; non-access instructions take 1 cycle.
- stall_out is high for exactly WAIT_STATES consecutive cycles per access, starting in the cycle the access is first presented.
- Back-to-back accesses: a new access presented in the cycle after completion starts from IDLE again.
- *_in values are sampled only on the completion edge, so changes during stall cycles are ignored.

## Configuration
- MEM_STAGE_MISALIGN_EN defined: an access with ALUOut_in[1:0]!=0 still takes the full latency but is not performed.
  - A store does not modify memory.
  - A load returns readData_out=0 and regWrite_out=0.
  - misalign_out=1 for one cycle after the completion edge.
- Undefined: ALUOut_in[1:0] is ignored and misalign_out is tied to 0.

## Test plan
- Reset with rst=0 mid-access (cnt=1) -> all outputs 0, stall_out=0, state IDLE; the store target word is unchanged.
- WAIT_STATES=2: store 0xDEADBEEF to 0x10, then load 0x10 with rd_in=5 -> stall_out high 2 cycles per access; readData_out=0xDEADBEEF, rd_out=5, regWrite_out=1 after the 3rd edge.
- WAIT_STATES=0: ALU op with ALUOut_in=0x1234, rd_in=7 -> ALUOut_out=0x1234 and rd_out=7 after 1 edge; stall_out never high.
- DEPTH=256: store 0x55 to 0x400, then load 0x000 -> reads 0x55 (wrap).
- memRead_in=memWrite_in=1 at 0x20 with data 0xA5 -> mem[8]=0xA5, readData_out=0.
- With MEM_STAGE_MISALIGN_EN: store to 0x22 -> memory unchanged, misalign_out pulses 1 cycle; without the macro, mem[8] is written.
